// File: rtl/uart_pkg.sv
// ============================================================================
// uart_pkg : shared types and constants for the UART TX scheduling slice
// Rev 1.0
// ============================================================================
`default_nettype none

package uart_pkg;

    localparam int         UART_DW  = 8;
    localparam logic [7:0] ADDR_TXB = 8'h00;
    localparam logic [7:0] ADDR_RXB = 8'h01;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_WAIT_ACK  = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_GAP       = 3'd4
    } tx_state_t;

endpackage

`default_nettype wire

// File: rtl/uart_tx_scheduler_if.sv
// ============================================================================
// uart_tx_scheduler_if : CPU push, transmitter handshake and status signals
// Rev 1.0
// ============================================================================
`default_nettype none

interface uart_tx_scheduler_if #(
    parameter int DEPTH = 4
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic                         WrStrobe;
    logic [uart_pkg::UART_DW-1:0] WrData;
    logic                         Enable;
    logic                         TxBusy;
    logic                         TxDone;
    logic                         ClrOvf;
    logic                         TxStart;
    logic [uart_pkg::UART_DW-1:0] TxData;
    logic                         Empty;
    logic                         Full;
    logic [LW-1:0]                Level;
    logic                         Overflow;
    logic                         Idle;

    modport master (
        output WrStrobe, WrData, Enable, TxBusy, TxDone, ClrOvf,
        input  TxStart, TxData, Empty, Full, Level, Overflow, Idle
    );

    modport slave (
        input  WrStrobe, WrData, Enable, TxBusy, TxDone, ClrOvf,
        output TxStart, TxData, Empty, Full, Level, Overflow, Idle
    );

endinterface

`default_nettype wire

// File: rtl/uart_sync_fifo.sv
// ============================================================================
// uart_sync_fifo : synchronous FIFO, extra pointer bit separates full/empty
// Rev 1.0
// ============================================================================
`default_nettype none

module uart_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  wire logic                     pClk,
    input  wire logic                     pReset,
    input  wire logic                     i_push,
    input  wire logic                     i_pop,
    input  wire logic [WIDTH-1:0]         i_wdata,
    output logic      [WIDTH-1:0]         o_rdata,
    output logic                          o_full,
    output logic                          o_empty,
    output logic      [$clog2(DEPTH):0]   o_level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop  && !o_empty;

    // Storage is not reset; the pointers alone define which entries are valid.
    always_ff @(posedge pClk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
        end
    end

    always_ff @(posedge pClk or negedge pReset) begin
        if (!pReset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    assign o_rdata = r_mem[r_rd_ptr[AW-1:0]];
    assign o_level = r_wr_ptr - r_rd_ptr;
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

endmodule

`default_nettype wire

// File: rtl/uart_tx_scheduler.sv
// ============================================================================
// uart_tx_scheduler : queues CPU bytes and paces them into the UART shifter
// Rev 1.0
// ============================================================================
`default_nettype none

module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int GAP_CYCLES = 0,
    parameter int GW         = 8
) (
    input  wire logic          pClk,
    input  wire logic          pReset,
    uart_tx_scheduler_if.slave bus
);

    localparam int            LW         = $clog2(DEPTH) + 1;
    localparam logic [GW-1:0] c_GAP_LOAD = GW'(GAP_CYCLES);

    tx_state_t            r_state;
    logic                 r_tx_start;
    logic [UART_DW-1:0]   r_tx_data;
    logic [GW-1:0]        r_gap_cnt;
    logic                 r_overflow;

    logic                 w_full;
    logic                 w_empty;
    logic [LW-1:0]        w_level;
    logic [UART_DW-1:0]   w_head;
    logic                 w_push;
    logic                 w_drop;
    logic                 w_pop;

    // Full is the registered occupancy, so a pop in the same cycle never frees room.
    assign w_push = bus.WrStrobe && !w_full;
    assign w_drop = bus.WrStrobe &&  w_full;
    assign w_pop  = (r_state == S_IDLE) && bus.Enable && !w_empty && !bus.TxBusy;

    uart_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (UART_DW)
    ) u_fifo (
        .pClk    (pClk),
        .pReset  (pReset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata (bus.WrData),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (w_level)
    );

    always_ff @(posedge pClk or negedge pReset) begin
        if (!pReset) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (bus.ClrOvf) begin
            r_overflow <= 1'b0;
        end
    end

    always_ff @(posedge pClk or negedge pReset) begin
        if (!pReset) begin
            r_state    <= S_IDLE;
            r_tx_start <= 1'b0;
            r_tx_data  <= '0;
            r_gap_cnt  <= '0;
        end else begin
            r_tx_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_tx_data  <= w_head;
                        r_tx_start <= 1'b1;
                        r_state    <= S_START;
                    end
                end
                S_START: begin
                    r_state <= S_WAIT_ACK;
                end
                S_WAIT_ACK: begin
                    if (bus.TxDone) begin
                        r_gap_cnt <= c_GAP_LOAD;
                        r_state   <= (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
                    end else if (bus.TxBusy) begin
                        r_state <= S_WAIT_DONE;
                    end
                end
                S_WAIT_DONE: begin
                    if (bus.TxDone) begin
                        r_gap_cnt <= c_GAP_LOAD;
                        r_state   <= (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
                    end
                end
                S_GAP: begin
                    // Leaving on a count of 1 yields exactly GAP_CYCLES cycles here.
                    r_gap_cnt <= r_gap_cnt - 1'b1;
                    if (r_gap_cnt <= 1) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.TxStart  = r_tx_start;
    assign bus.TxData   = r_tx_data;
    assign bus.Empty    = w_empty;
    assign bus.Full     = w_full;
    assign bus.Level    = w_level;
    assign bus.Overflow = r_overflow;
    assign bus.Idle     = (r_state == S_IDLE) && w_empty;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_scheduler.sv
// ============================================================================
// tb_uart_tx_scheduler : directed checks on a no-gap and a 3-cycle-gap instance
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_uart_tx_scheduler;

    logic pClk;
    logic pReset;
    int   n_vec;
    int   n_err;

    uart_tx_scheduler_if #(.DEPTH(4)) if0 ();
    uart_tx_scheduler_if #(.DEPTH(4)) if3 ();

    uart_tx_scheduler #(.DEPTH(4), .GAP_CYCLES(0), .GW(8)) u_dut0 (
        .pClk   (pClk),
        .pReset (pReset),
        .bus    (if0)
    );

    uart_tx_scheduler #(.DEPTH(4), .GAP_CYCLES(3), .GW(8)) u_dut3 (
        .pClk   (pClk),
        .pReset (pReset),
        .bus    (if3)
    );

    initial pClk = 1'b0;
    always #5 pClk = ~pClk;

    task automatic tick();
        @(posedge pClk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One frame on the no-gap instance: TxStart is already high on entry.
    task automatic xmit0(input logic [7:0] exp_byte);
        chk("burst_start", 32'(if0.TxStart), 32'h1);
        chk("burst_data",  32'(if0.TxData),  32'(exp_byte));
        if0.TxBusy = 1'b1;
        tick();
        chk("burst_start_clr", 32'(if0.TxStart), 32'h0);
        tick();
        if0.TxBusy = 1'b0;
        if0.TxDone = 1'b1;
        tick();
        if0.TxDone = 1'b0;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        pReset = 1'b0;
        {if0.WrStrobe, if0.Enable, if0.TxBusy, if0.TxDone, if0.ClrOvf} = '0;
        {if3.WrStrobe, if3.Enable, if3.TxBusy, if3.TxDone, if3.ClrOvf} = '0;
        if0.WrData = 8'h00;
        if3.WrData = 8'h00;
        #1;
        chk("rst_txstart",  32'(if0.TxStart),  32'h0);
        chk("rst_txdata",   32'(if0.TxData),   32'h0);
        chk("rst_empty",    32'(if0.Empty),    32'h1);
        chk("rst_full",     32'(if0.Full),     32'h0);
        chk("rst_level",    32'(if0.Level),    32'h0);
        chk("rst_overflow", 32'(if0.Overflow), 32'h0);
        chk("rst_idle",     32'(if0.Idle),     32'h1);
        tick();
        pReset = 1'b1;
        tick();

        // Single byte, no gap
        if0.Enable   = 1'b1;
        if0.WrStrobe = 1'b1;
        if0.WrData   = 8'hA5;
        tick();
        if0.WrStrobe = 1'b0;
        chk("single_empty_n", 32'(if0.Empty),   32'h0);
        chk("single_level1",  32'(if0.Level),   32'h1);
        chk("single_nostart", 32'(if0.TxStart), 32'h0);
        tick();
        chk("single_start", 32'(if0.TxStart), 32'h1);
        chk("single_data",  32'(if0.TxData),  32'hA5);
        chk("single_empty", 32'(if0.Empty),   32'h1);
        if0.TxBusy = 1'b1;
        tick();
        chk("single_start_1cyc", 32'(if0.TxStart), 32'h0);
        for (int i = 0; i < 10; i++) tick();
        chk("single_busy_idle", 32'(if0.Idle), 32'h0);
        if0.TxDone = 1'b1;
        tick();
        if0.TxDone = 1'b0;
        if0.TxBusy = 1'b0;
        chk("single_idle",     32'(if0.Idle),   32'h1);
        chk("single_data_hold", 32'(if0.TxData), 32'hA5);
        if0.Enable = 1'b0;
        tick();

        // Burst and overflow with Enable low
        for (int i = 1; i <= 5; i++) begin
            if0.WrStrobe = 1'b1;
            if0.WrData   = 8'(i);
            tick();
            if (i == 4) begin
                chk("burst_full4", 32'(if0.Full),     32'h1);
                chk("burst_novf4", 32'(if0.Overflow), 32'h0);
            end
        end
        if0.WrStrobe = 1'b0;
        chk("burst_level", 32'(if0.Level),    32'h4);
        chk("burst_full",  32'(if0.Full),     32'h1);
        chk("burst_ovf",   32'(if0.Overflow), 32'h1);

        // Set wins over clear
        if0.WrStrobe = 1'b1;
        if0.WrData   = 8'h66;
        if0.ClrOvf   = 1'b1;
        tick();
        if0.WrStrobe = 1'b0;
        chk("ovf_set_wins", 32'(if0.Overflow), 32'h1);
        tick();
        if0.ClrOvf = 1'b0;
        chk("ovf_cleared", 32'(if0.Overflow), 32'h0);

        // Push into full FIFO in the same cycle as a pop: dropped
        if0.Enable   = 1'b1;
        if0.WrStrobe = 1'b1;
        if0.WrData   = 8'h77;
        tick();
        if0.WrStrobe = 1'b0;
        chk("pushpop_level", 32'(if0.Level),    32'h3);
        chk("pushpop_ovf",   32'(if0.Overflow), 32'h1);
        for (int i = 1; i <= 4; i++) xmit0(8'(i));
        chk("burst_no5th",  32'(if0.TxStart), 32'h0);
        chk("burst_drain",  32'(if0.Level),   32'h0);
        chk("burst_lastd",  32'(if0.TxData),  32'h04);
        chk("burst_idle",   32'(if0.Idle),    32'h1);
        if0.Enable = 1'b0;

        // Inter-frame gap on the GAP_CYCLES=3 instance
        if3.Enable   = 1'b1;
        if3.WrStrobe = 1'b1;
        if3.WrData   = 8'h11;
        tick();
        if3.WrData   = 8'h22;
        tick();
        if3.WrStrobe = 1'b0;
        chk("gap_start1", 32'(if3.TxStart), 32'h1);
        chk("gap_data1",  32'(if3.TxData),  32'h11);
        chk("gap_level1", 32'(if3.Level),   32'h1);
        if3.TxBusy = 1'b1;
        tick();
        tick();
        if3.TxBusy = 1'b0;
        if3.TxDone = 1'b1;
        tick();
        if3.TxDone = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("gap_hold", 32'(if3.TxStart), 32'h0);
        end
        tick();
        chk("gap_start2", 32'(if3.TxStart), 32'h1);
        chk("gap_data2",  32'(if3.TxData),  32'h22);
        if3.TxBusy = 1'b1;
        tick();
        tick();
        if3.TxBusy = 1'b0;
        if3.TxDone = 1'b1;
        tick();
        if3.TxDone = 1'b0;
        tick();
        tick();
        chk("gap_not_idle", 32'(if3.Idle), 32'h0);
        tick();
        chk("gap_idle", 32'(if3.Idle), 32'h1);
        if3.Enable = 1'b0;

        // Enable dropped during WAIT_DONE
        if0.Enable   = 1'b1;
        if0.WrStrobe = 1'b1;
        if0.WrData   = 8'hA1;
        tick();
        if0.WrData   = 8'hA2;
        tick();
        chk("en_start", 32'(if0.TxStart), 32'h1);
        if0.WrData   = 8'hA3;
        if0.TxBusy   = 1'b1;
        tick();
        if0.WrStrobe = 1'b0;
        tick();
        if0.Enable = 1'b0;
        tick();
        if0.TxBusy = 1'b0;
        if0.TxDone = 1'b1;
        tick();
        if0.TxDone = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("en_nostart", 32'(if0.TxStart), 32'h0);
        end
        chk("en_level2", 32'(if0.Level),  32'h2);
        chk("en_data",   32'(if0.TxData), 32'hA1);

        // Asynchronous reset while TxStart is high
        if0.Enable = 1'b1;
        tick();
        chk("rst_pre_start", 32'(if0.TxStart), 32'h1);
        chk("rst_pre_data",  32'(if0.TxData),  32'hA2);
        #2;
        pReset = 1'b0;
        #1;
        chk("arst_level",    32'(if0.Level),    32'h0);
        chk("arst_txdata",   32'(if0.TxData),   32'h0);
        chk("arst_txstart",  32'(if0.TxStart),  32'h0);
        chk("arst_idle",     32'(if0.Idle),     32'h1);
        chk("arst_overflow", 32'(if0.Overflow), 32'h0);
        tick();
        pReset = 1'b1;
        tick();
        tick();
        chk("post_rst_nostart", 32'(if0.TxStart), 32'h0);
        chk("post_rst_empty",   32'(if0.Empty),   32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
